// File: rtl/ppu_timing_pkg.sv
// ppu_timing_pkg: shared PPU raster constants and the frame-length helper.
package ppu_timing_pkg;
    localparam logic [8:0] H_LAST      = 9'd340;
    localparam logic [8:0] H_SKIP      = 9'd339;
    localparam logic [8:0] V_PRE       = 9'd511;
    localparam logic [8:0] V_LAST_NTSC = 9'd260;
    localparam logic [8:0] V_LAST_PAL  = 9'd310;
    localparam logic [8:0] VBL_LINE    = 9'd241;
    localparam logic [8:0] VBL_DOT     = 9'd1;

    function automatic logic [8:0] last_line(input logic pal);
        return pal ? V_LAST_PAL : V_LAST_NTSC;
    endfunction
endpackage

// File: rtl/ce_divider.sv
// ce_divider: divides clk into a one-clk dot enable and a half-phase companion.
module ce_divider #(
    parameter int CE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_ce,
    output logic pix_ce_n
);
    localparam int W = $clog2(CE_DIV);
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    assign cnt_nxt = (cnt == W'(CE_DIV - 1)) ? '0 : cnt + 1'b1;
    // enables are registered copies of the decode of the next count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            pix_ce   <= 1'b0;
            pix_ce_n <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            pix_ce   <= cnt_nxt == '0;
            pix_ce_n <= cnt_nxt == W'(CE_DIV / 2);
        end
    end
endmodule

// File: rtl/ppu_timing_gen.sv
// ppu_timing_gen: NES/PAL PPU dot and line counters, vblank, frame parity and odd-frame dot skip.
module ppu_timing_gen
    import ppu_timing_pkg::*;
#(
    parameter int CE_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rendering_en,
    input  logic       pal,
    output logic       pix_ce,
    output logic       pix_ce_n,
    output logic [8:0] count_h,
    output logic [8:0] count_v,
    output logic       vblank,
    output logic       frame_start,
    output logic       frame_odd
);
    logic       pal_q;
    logic       skip;
    logic       h_end;
    logic       frame_load;
    logic [8:0] h_nxt;
    logic [8:0] v_nxt;

    ce_divider #(.CE_DIV(CE_DIV)) u_div (
        .clk     (clk),
        .reset   (reset),
        .pix_ce  (pix_ce),
        .pix_ce_n(pix_ce_n)
    );

    // frame length follows the standard latched at the last frame boundary
    assign skip       = !pal_q && rendering_en && frame_odd && count_v == V_PRE && count_h == H_SKIP;
    assign h_end      = count_h == H_LAST || skip;
    assign frame_load = h_end && count_v == V_PRE;
    assign h_nxt      = h_end ? '0 : count_h + 9'd1;
    assign v_nxt      = !h_end ? count_v :
                        count_v == V_PRE ? '0 :
                        count_v == last_line(pal_q) ? V_PRE : count_v + 9'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_h     <= '0;
            count_v     <= V_PRE;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            frame_odd   <= 1'b0;
            pal_q       <= 1'b0;
        end else begin
            frame_start <= pix_ce && frame_load;
            if (pix_ce) begin
                count_h <= h_nxt;
                count_v <= v_nxt;
                vblank  <= (h_nxt == VBL_DOT && v_nxt == VBL_LINE) ? 1'b1 :
                           (h_nxt == VBL_DOT && v_nxt == V_PRE) ? 1'b0 : vblank;
                if (frame_load) begin
                    frame_odd <= !frame_odd;
                    pal_q     <= pal;
                end
            end
        end
    end
endmodule

// File: tb/tb_ppu_timing_gen.sv
// tb_ppu_timing_gen: directed dot-transition vectors plus reset, divider, first-frame and vblank sequences.
module tb_ppu_timing_gen;
    localparam int CE_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rendering_en = 1'b0;
    logic       pal = 1'b0;
    logic       pix_ce, pix_ce_n, vblank, frame_start, frame_odd;
    logic [8:0] count_h, count_v;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [8:0] h, v;
        logic       odd, vbl, pq, pal, ren;
        logic [8:0] eh, ev;
        logic       evbl, efs, eodd;
    } vec_t;
    vec_t vecs[$];

    logic [8:0] j_h, j_v;
    logic       j_odd, j_vbl, j_pq;
    int n, hi, vmax, rise_h, rise_v, seen, fs_cnt, bad_v;

    ppu_timing_gen #(.CE_DIV(CE_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .rendering_en(rendering_en),
        .pal         (pal),
        .pix_ce      (pix_ce),
        .pix_ce_n    (pix_ce_n),
        .count_h     (count_h),
        .count_v     (count_v),
        .vblank      (vblank),
        .frame_start (frame_start),
        .frame_odd   (frame_odd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advances to the first clk edge taken with pix_ce high; leaves time at edge+1.
    task automatic step_dot();
        int k = 0;
        while (pix_ce !== 1'b1 && k < 4 * CE_DIV) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (pix_ce !== 1'b1) check("pix_ce_timeout", 32'(pix_ce), 1);
        @(posedge clk);
        #1;
    endtask

    // Places the raster at an arbitrary dot so distant boundaries are reachable quickly.
    task jump(input logic [8:0] h, input logic [8:0] v, input logic odd, input logic vbl, input logic pq);
        j_h = h; j_v = v; j_odd = odd; j_vbl = vbl; j_pq = pq;
        force dut.count_h = j_h;
        force dut.count_v = j_v;
        force dut.frame_odd = j_odd;
        force dut.vblank = j_vbl;
        force dut.pal_q = j_pq;
        #1;
        release dut.count_h;
        release dut.count_v;
        release dut.frame_odd;
        release dut.vblank;
        release dut.pal_q;
    endtask

    task jump_hv(input logic [8:0] h, input logic [8:0] v);
        j_h = h; j_v = v;
        force dut.count_h = j_h;
        force dut.count_v = j_v;
        #1;
        release dut.count_h;
        release dut.count_v;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_ce"}, 32'(pix_ce), 0);
        check({tag, "_pix_ce_n"}, 32'(pix_ce_n), 0);
        check({tag, "_count_h"}, 32'(count_h), 0);
        check({tag, "_count_v"}, 32'(count_v), 511);
        check({tag, "_vblank"}, 32'(vblank), 0);
        check({tag, "_frame_start"}, 32'(frame_start), 0);
        check({tag, "_frame_odd"}, 32'(frame_odd), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //                name            h        v     odd   vbl   pq    pal   ren    eh       ev    evbl  efs   eodd
        vecs.push_back('{"h_inc",        9'd0,   9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd1,   9'd0,   1'b0, 1'b0, 1'b0});
        vecs.push_back('{"h_339",        9'd339, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd340, 9'd0,   1'b0, 1'b0, 1'b0});
        vecs.push_back('{"line_wrap",    9'd340, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd1,   1'b0, 1'b0, 1'b0});
        vecs.push_back('{"to_241",       9'd340, 9'd240, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd241, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"vbl_rise",     9'd0,   9'd241, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd1,   9'd241, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"vbl_hold",     9'd340, 9'd241, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0,   9'd242, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"ntsc_last",    9'd340, 9'd260, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd0,   9'd511, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"pal_261",      9'd340, 9'd260, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0,   9'd261, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"pal_last",     9'd340, 9'd310, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd0,   9'd511, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"vbl_fall",     9'd0,   9'd511, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd1,   9'd511, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"skip",         9'd339, 9'd511, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0,   9'd0,   1'b0, 1'b1, 1'b0});
        vecs.push_back('{"noskip_ren0",  9'd339, 9'd511, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd340, 9'd511, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"noskip_even",  9'd339, 9'd511, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd340, 9'd511, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"noskip_pal",   9'd339, 9'd511, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd340, 9'd511, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"noskip_line",  9'd339, 9'd100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'd340, 9'd100, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"frame_even",   9'd340, 9'd511, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0,   9'd0,   1'b0, 1'b1, 1'b1});
        vecs.push_back('{"frame_odd",    9'd340, 9'd511, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   1'b0, 1'b1, 1'b0});

        // Reset held: all outputs at reset values.
        #12;
        check_reset_vals("rst_hold");

        // Divider phase after release.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("pix_ce_clk%0d", k), 32'(pix_ce), 32'(k % 4 == 0));
            check($sformatf("pix_ce_n_clk%0d", k), 32'(pix_ce_n), 32'(k % 4 == 2));
            check($sformatf("count_v_clk%0d", k), 32'(count_v), 511);
        end
        check("count_h_after_12", 32'(count_h), 2);

        // First frame leaves the pre-render line in full (parity still even, no skip).
        rendering_en = 1'b1;
        n = 0;
        bad_v = 0;
        do begin
            step_dot();
            n++;
            if (!frame_start && count_v != 9'd511) bad_v++;
        end while (!frame_start && n < 400);
        check("first_frame_dots", n, 339);
        check("first_pre_render_v", bad_v, 0);
        check("first_frame_h", 32'(count_h), 0);
        check("first_frame_v", 32'(count_v), 0);
        check("first_frame_odd", 32'(frame_odd), 1);
        @(posedge clk);
        #1;
        check("frame_start_width", 32'(frame_start), 0);

        // Single-dot transitions at the raster boundaries.
        foreach (vecs[i]) begin
            pal = vecs[i].pal;
            rendering_en = vecs[i].ren;
            jump(vecs[i].h, vecs[i].v, vecs[i].odd, vecs[i].vbl, vecs[i].pq);
            step_dot();
            check({vecs[i].name, "_h"}, 32'(count_h), 32'(vecs[i].eh));
            check({vecs[i].name, "_v"}, 32'(count_v), 32'(vecs[i].ev));
            check({vecs[i].name, "_vblank"}, 32'(vblank), 32'(vecs[i].evbl));
            check({vecs[i].name, "_frame_start"}, 32'(frame_start), 32'(vecs[i].efs));
            check({vecs[i].name, "_frame_odd"}, 32'(frame_odd), 32'(vecs[i].eodd));
        end

        // pal is latched only at the frame boundary.
        rendering_en = 1'b0;
        pal = 1'b1;
        jump(9'd340, 9'd511, 1'b0, 1'b0, 1'b0);
        step_dot();
        pal = 1'b0;
        jump_hv(9'd340, 9'd260);
        step_dot();
        check("pal_latched_261", 32'(count_v), 261);
        jump_hv(9'd340, 9'd310);
        step_dot();
        check("pal_latched_end", 32'(count_v), 511);
        jump_hv(9'd340, 9'd511);
        step_dot();
        jump_hv(9'd340, 9'd260);
        step_dot();
        check("ntsc_relatched_end", 32'(count_v), 511);

        // NTSC vblank width measured over a real run.
        jump(9'd340, 9'd240, 1'b0, 1'b0, 1'b0);
        n = 0; hi = 0; vmax = 0; seen = 0; rise_h = 0; rise_v = 0;
        do begin
            step_dot();
            n++;
            if (vblank) begin
                if (seen == 0) begin
                    rise_h = 32'(count_h);
                    rise_v = 32'(count_v);
                end
                seen = 1;
                hi++;
                if (count_v != 9'd511 && 32'(count_v) > vmax) vmax = 32'(count_v);
            end
        end while ((seen == 0 || vblank) && n < 8000);
        check("vbl_rise_h", rise_h, 1);
        check("vbl_rise_v", rise_v, 241);
        check("vbl_dots_ntsc", hi, 6820);
        check("vbl_max_line", vmax, 260);
        check("vbl_fall_h", 32'(count_h), 1);
        check("vbl_fall_v", 32'(count_v), 511);

        // Reset mid-frame: asynchronous clear, restart at (0,511), no frame_start.
        jump(9'd100, 9'd150, 1'b1, 1'b0, 1'b0);
        step_dot();
        step_dot();
        check("pre_reset_h", 32'(count_h), 102);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("rst_async");
        fs_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (frame_start) fs_cnt++;
        end
        @(negedge clk);
        reset = 1'b0;
        step_dot();
        check("restart_h", 32'(count_h), 1);
        check("restart_v", 32'(count_v), 511);
        for (int k = 0; k < 4; k++) begin
            step_dot();
            if (frame_start) fs_cnt++;
        end
        check("restart_no_frame_start", fs_cnt, 0);
        check("restart_h5", 32'(count_h), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
